cache_stats_unit: RTL and testbench

- Synthesizable statistics block for the L2 cache model. Counts hit/miss/read/write events independently for each of CHANNELS requesters.
- On command, it snapshots the counters, optionally clears them, then streams the snapshot out as records over a valid/ready port.
- It replaces the bench-side unconditional print with a clocked, multi-channel, saturating, back-pressured readout. It sits beside the L2 cache and feeds the bench monitor or a log writer.

---
 rtl/cache_stats_pkg.sv | 31 +++
 rtl/cache_stats_unit_sat_counter.sv | 36 +++
 rtl/cache_stats_unit.sv | 142 ++++++++++++++
 tb/tb_cache_stats_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_stats_pkg.sv
// Shared types for the L2 cache statistics unit: command opcodes, event kinds, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_stats_pkg;

  // Readout command opcodes as they appear on cmd_op
  typedef enum logic [1:0] {
    CMD_NOP        = 2'd0,
    CMD_SNAP       = 2'd1,
    CMD_CLEAR      = 2'd2,
    CMD_SNAP_CLEAR = 2'd3
  } stat_cmd_e;

  // Event kinds, also the low bits of the record index within a channel
  typedef enum logic [1:0] {
    KIND_HIT   = 2'd0,
    KIND_MISS  = 2'd1,
    KIND_READ  = 2'd2,
    KIND_WRITE = 2'd3
  } stat_kind_e;

  localparam int NUM_KINDS = 4;
  localparam int KIND_W    = 2;

  // Readout controller states
  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_e;

endpackage

// File: rtl/cache_stats_unit_sat_counter.sv
// Saturating event counter with a sticky overflow flag and a synchronous load-on-clear.
// Latency: count reflects an increment one cycle after the strobe.
// Backpressure: none; every strobe is counted or flagged as saturated.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             clr_val,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Count strobes up to the maximum; a strobe at the maximum only sets the sticky flag.
  // Clear wins over increment but keeps that cycle's event by loading clr_val.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= {{(CNT_W-1){1'b0}}, clr_val};
      sat   <= 1'b0;
    end else if (inc) begin
      if (count == CNT_MAX) begin
        sat <= 1'b1;
      end else begin
        count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/cache_stats_unit.sv
// Per-channel hit/miss/read/write counters with snapshot/clear commands and a streamed record readout.
// Latency: first record is valid the cycle after SNAP/SNAP_CLEAR is accepted; one record per rec handshake.
// Backpressure: rec_ready low holds the current record stable; cmd_ready stays low for the whole dump.
module cache_stats_unit
  import cache_stats_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] hit_i,
  input  logic [CHANNELS-1:0] miss_i,
  input  logic [CHANNELS-1:0] read_i,
  input  logic [CHANNELS-1:0] write_i,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_op,
  output logic                cmd_ready,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic [CH_W-1:0]     rec_chan,
  output logic [1:0]          rec_kind,
  output logic [CNT_W-1:0]    rec_count,
  output logic                rec_sat,
  output logic                rec_last,
  output logic                busy
);

  localparam int NUM_REC = CHANNELS * NUM_KINDS;
  localparam int IDX_W   = $clog2(NUM_REC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REC - 1);

  logic [NUM_REC-1:0] strobe;
  logic [CNT_W-1:0]   liveCnt [NUM_REC];
  logic [NUM_REC-1:0] liveSat;
  logic [CNT_W-1:0]   snapCnt [NUM_REC];
  logic [NUM_REC-1:0] snapSat;

  state_e           state;
  logic [IDX_W-1:0] recIdx;
  logic [IDX_W-1:0] nextIdx;
  stat_cmd_e        cmdOp;
  logic             cmdAccept;
  logic             doSnap;
  logic             doClear;

  assign cmdOp     = stat_cmd_e'(cmd_op);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state == DUMP);
  assign cmdAccept = cmd_valid && cmd_ready;
  assign doSnap    = cmdAccept && ((cmdOp == CMD_SNAP) || (cmdOp == CMD_SNAP_CLEAR));
  assign doClear   = cmdAccept && ((cmdOp == CMD_CLEAR) || (cmdOp == CMD_SNAP_CLEAR));
  assign nextIdx   = recIdx + IDX_W'(1);

  // Flatten strobes channel-major so that index = chan*NUM_KINDS + kind, matching readout order
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : gStrobe
    assign strobe[ch*NUM_KINDS +: NUM_KINDS] = {write_i[ch], read_i[ch], miss_i[ch], hit_i[ch]};
  end

  // One live saturating counter per (channel, kind); counting never pauses for the FSM
  for (genvar i = 0; i < NUM_REC; i++) begin : gCnt
    sat_counter #(
      .CNT_W(CNT_W)
    ) uCnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (strobe[i]),
      .clr    (doClear),
      .clr_val(strobe[i]),
      .count  (liveCnt[i]),
      .sat    (liveSat[i])
    );
  end

  // Freeze the pre-increment live values and sticky flags when a snapshot is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REC; i++) begin
        snapCnt[i] <= '0;
      end
      snapSat <= '0;
    end else if (doSnap) begin
      for (int i = 0; i < NUM_REC; i++) begin
        snapCnt[i] <= liveCnt[i];
      end
      snapSat <= liveSat;
    end
  end

  // Readout FSM with registered record outputs. Record 0 is loaded straight from the live
  // counters at the accept edge (same values the snapshot captures), later records from the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      recIdx    <= '0;
      rec_valid <= 1'b0;
      rec_last  <= 1'b0;
      rec_chan  <= '0;
      rec_kind  <= '0;
      rec_count <= '0;
      rec_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (doSnap) begin
            state     <= DUMP;
            recIdx    <= '0;
            rec_valid <= 1'b1;
            rec_last  <= (NUM_REC == 1);
            rec_chan  <= '0;
            rec_kind  <= KIND_HIT;
            rec_count <= liveCnt[0];
            rec_sat   <= liveSat[0];
          end
        end
        DUMP: begin
          if (rec_ready) begin
            if (rec_last) begin
              state     <= IDLE;
              rec_valid <= 1'b0;
              rec_last  <= 1'b0;
            end else begin
              recIdx    <= nextIdx;
              rec_chan  <= CH_W'(nextIdx >> KIND_W);
              rec_kind  <= nextIdx[KIND_W-1:0];
              rec_count <= snapCnt[nextIdx];
              rec_sat   <= snapSat[nextIdx];
              rec_last  <= (nextIdx == LAST_IDX);
            end
          end
        end
        default: begin
          state     <= IDLE;
          rec_valid <= 1'b0;
          rec_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_stats_unit.sv
// Directed bench for cache_stats_unit: expected records are queued at stimulus time,
// a monitor pops and compares on every record handshake.
module tb_cache_stats_unit;
  import cache_stats_pkg::*;

  localparam int CHANNELS = 4;
  localparam int CNT_W    = 8;
  localparam int CH_W     = 2;
  localparam int NUM_REC  = CHANNELS * NUM_KINDS;

  typedef struct packed {
    logic [CH_W-1:0]  chan;
    logic [1:0]       kind;
    logic [CNT_W-1:0] count;
    logic             sat;
    logic             last;
  } rec_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [CHANNELS-1:0] hit_i = '0;
  logic [CHANNELS-1:0] miss_i = '0;
  logic [CHANNELS-1:0] read_i = '0;
  logic [CHANNELS-1:0] write_i = '0;
  logic                cmd_valid = 1'b0;
  logic [1:0]          cmd_op = 2'd0;
  logic                cmd_ready;
  logic                rec_valid;
  logic                rec_ready = 1'b1;
  logic [CH_W-1:0]     rec_chan;
  logic [1:0]          rec_kind;
  logic [CNT_W-1:0]    rec_count;
  logic                rec_sat;
  logic                rec_last;
  logic                busy;

  int   nChecks = 0;
  int   nFails  = 0;
  rec_t expQ[$];
  int   expCnt[NUM_REC];
  bit   expSat[NUM_REC];
  rec_t monExp;
  rec_t monGot;

  cache_stats_unit #(
    .CHANNELS(CHANNELS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hit_i    (hit_i),
    .miss_i   (miss_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_ready(cmd_ready),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_chan (rec_chan),
    .rec_kind (rec_kind),
    .rec_count(rec_count),
    .rec_sat  (rec_sat),
    .rec_last (rec_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  task automatic clearExp();
    for (int i = 0; i < NUM_REC; i++) begin
      expCnt[i] = 0;
      expSat[i] = 1'b0;
    end
  endtask

  // Queue the first n records of a dump built from expCnt/expSat
  task automatic pushDump(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r.chan  = CH_W'(i / NUM_KINDS);
      r.kind  = 2'(i % NUM_KINDS);
      r.count = CNT_W'(expCnt[i]);
      r.sat   = expSat[i];
      r.last  = (i == NUM_REC - 1);
      expQ.push_back(r);
    end
  endtask

  // Present a command for exactly one cycle; returns 1 time unit after the accept edge
  task automatic issue(input logic [1:0] op);
    check("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  task automatic checkStart();
    check("dump_start_rec_valid", rec_valid, 1);
    check("dump_start_busy", busy, 1);
    check("dump_start_cmd_ready", cmd_ready, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("dump_finished_in_budget", busy, 0);
    check("queue_drained", expQ.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: compare every record that is handshaked against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && rec_valid && rec_ready) begin
      monGot = {rec_chan, rec_kind, rec_count, rec_sat, rec_last};
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_record: actual 0x%0h required no record", monGot);
      end else begin
        monExp = expQ.pop_front();
        check($sformatf("record_ch%0d_kind%0d", monExp.chan, monExp.kind), monGot, monExp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, actual running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rec_valid", rec_valid, 0);
    check("reset_rec_last", rec_last, 0);
    check("reset_busy", busy, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rec_chan", rec_chan, 0);
    check("reset_rec_kind", rec_kind, 0);
    check("reset_rec_count", rec_count, 0);
    check("reset_rec_sat", rec_sat, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SNAP with no events: 16 zero records, last only on chan3/write
    clearExp();
    pushDump(NUM_REC);
    issue(CMD_SNAP);
    checkStart();
    drain();

    // 5 hits on chan2, 3 writes on chan0
    for (int i = 0; i < 5; i++) begin
      hit_i[2] = 1'b1;
      @(posedge clk); #1;
      hit_i[2] = 1'b0;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      write_i[0] = 1'b1;
      @(posedge clk); #1;
      write_i[0] = 1'b0;
      @(posedge clk); #1;
    end
    clearExp();
    expCnt[8] = 5;
    expCnt[3] = 3;
    pushDump(NUM_REC);
    issue(CMD_SNAP);
    checkStart();
    drain();
    pushDump(NUM_REC);
    issue(CMD_SNAP);
    checkStart();
    drain();

    // SNAP_CLEAR together with a chan1 read: snapshot excludes it, live keeps it
    clearExp();
    expCnt[8] = 5;
    expCnt[3] = 3;
    pushDump(NUM_REC);
    read_i[1] = 1'b1;
    issue(CMD_SNAP_CLEAR);
    read_i[1] = 1'b0;
    checkStart();
    drain();
    clearExp();
    expCnt[6] = 1;
    pushDump(NUM_REC);
    issue(CMD_SNAP);
    checkStart();
    drain();

    // CLEAR produces no readout; then saturate chan0 hit with 300 events
    issue(CMD_CLEAR);
    check("clear_no_rec_valid", rec_valid, 0);
    check("clear_no_busy", busy, 0);
    hit_i[0] = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    hit_i[0] = 1'b0;
    clearExp();
    expCnt[0] = 255;
    expSat[0] = 1'b1;
    pushDump(NUM_REC);
    issue(CMD_SNAP);
    checkStart();
    drain();
    issue(CMD_CLEAR);
    clearExp();
    pushDump(NUM_REC);
    issue(CMD_SNAP);
    checkStart();
    drain();

    // Stall on record 13 (chan3/miss = 2) while strobing everything and requesting SNAP
    for (int i = 0; i < 2; i++) begin
      miss_i[3] = 1'b1;
      @(posedge clk); #1;
      miss_i[3] = 1'b0;
      @(posedge clk); #1;
    end
    clearExp();
    expCnt[13] = 2;
    pushDump(NUM_REC);
    issue(CMD_SNAP);
    checkStart();
    repeat (13) @(posedge clk);
    #1;
    rec_ready = 1'b0;
    hit_i     = '1;
    miss_i    = '1;
    read_i    = '1;
    write_i   = '1;
    cmd_valid = 1'b1;
    cmd_op    = 2'(CMD_SNAP);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_rec_valid", rec_valid, 1);
      check("stall_rec_chan", rec_chan, 3);
      check("stall_rec_kind", rec_kind, 1);
      check("stall_rec_count", rec_count, 2);
      check("stall_rec_sat", rec_sat, 0);
      check("stall_cmd_ready", cmd_ready, 0);
      @(posedge clk); #1;
    end
    hit_i     = '0;
    miss_i    = '0;
    read_i    = '0;
    write_i   = '0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    rec_ready = 1'b1;
    drain();

    // Live counters now hold 10 each (chan3/miss 12); reset while the 7th record is shown
    clearExp();
    for (int i = 0; i < NUM_REC; i++) expCnt[i] = 10;
    expCnt[13] = 12;
    pushDump(6);
    issue(CMD_SNAP);
    checkStart();
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_rec_valid", rec_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_partial_records_seen", expQ.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clearExp();
    pushDump(NUM_REC);
    issue(CMD_SNAP);
    checkStart();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
